// File: rtl/arcade_input_pkg.sv
// Shared bit positions and coin pulser state type for the arcade input mapper.
package arcade_input_pkg;

    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_COIN  = 4;
    localparam int JOY_START = 5;
    localparam int JOY_BTN1  = 6;

    localparam int PORT_UP    = 0;
    localparam int PORT_DOWN  = 1;
    localparam int PORT_LEFT  = 2;
    localparam int PORT_RIGHT = 3;
    localparam int PORT_BTN1  = 4;
    localparam int PORT_START = 5;
    localparam int PORT_COIN  = 6;
    localparam int PORT_SPARE = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    // Directions are kept in in_port order (up = bit 0), so the lowest set bit is the priority winner.
    function automatic logic [3:0] pick_priority(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_pulser.sv
// Converts coin presses into fixed-length active-low pulses separated by a minimum gap,
// queuing presses that arrive while a pulse or gap is in progress.
module coin_pulser
    import arcade_input_pkg::*;
#(
    parameter logic [15:0] COIN_PULSE = 16'd50000,
    parameter logic [15:0] COIN_GAP   = 16'd50000,
    parameter int          PEND_MAX   = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic coin_in,
    output logic coin_n,
    output logic busy
);

    localparam int MAXLEN = (COIN_PULSE > COIN_GAP) ? int'(COIN_PULSE) : int'(COIN_GAP);
    localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam int PW     = $clog2(PEND_MAX + 1);

    localparam logic [CW-1:0] PULSE_LOAD = CW'(COIN_PULSE - 16'd1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(COIN_GAP - 16'd1);
    localparam logic [PW-1:0] PEND_FULL  = PW'(PEND_MAX);

    coin_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [PW-1:0] pend, pend_nx;
    logic          coin_prev;
    logic          rise, launch, accept;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        launch   = 1'b0;
        case (state)
            IDLE: begin
                if (pend != '0) begin
                    launch   = 1'b1;
                    state_nx = PULSE;
                    cnt_nx   = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nx = GAP;
                    cnt_nx   = GAP_LOAD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (pend != '0) begin
                        launch   = 1'b1;
                        state_nx = PULSE;
                        cnt_nx   = PULSE_LOAD;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // A press coinciding with a launch frees its own slot, so it is kept even when full.
        rise    = coin_in & ~coin_prev;
        accept  = rise & ((pend != PEND_FULL) | launch);
        pend_nx = pend;
        if (accept && !launch) begin
            pend_nx = pend + 1'b1;
        end else if (launch && !accept) begin
            pend_nx = pend - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pend      <= '0;
            coin_prev <= 1'b0;
            coin_n    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            pend      <= pend_nx;
            coin_prev <= coin_in;
            coin_n    <= (state_nx != PULSE);
            busy      <= (state_nx != IDLE) || (pend_nx != '0);
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Maps HPS joystick words to active-low arcade IN ports with per-player 4/8-way
// direction filtering and coin pulse shaping.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int          PLAYERS    = 2,
    parameter logic [15:0] COIN_PULSE = 16'd50000,
    parameter logic [15:0] COIN_GAP   = 16'd50000,
    parameter int          PEND_MAX   = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [PLAYERS-1:0][15:0] joystick,
    input  logic [PLAYERS-1:0]       fourway,
    output logic [PLAYERS-1:0][7:0]  in_port,
    output logic [PLAYERS-1:0]       coin_busy
);

    logic [PLAYERS-1:0] unused_joy;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [3:0] dirs, dirs_prev, held, rises, sel, dir_out;
        logic [5:0] port_lo;
        logic       coin_n;

        assign unused_joy[p] = ^joystick[p][15:7];

        assign dirs = {joystick[p][JOY_RIGHT], joystick[p][JOY_LEFT],
                       joystick[p][JOY_DOWN],  joystick[p][JOY_UP]};

        // New presses beat the held direction; otherwise keep it while held, else fall back to priority.
        always_comb begin
            rises = dirs & ~dirs_prev;
            if (rises != '0) begin
                sel = pick_priority(rises);
            end else if ((held & dirs) != '0) begin
                sel = held;
            end else begin
                sel = pick_priority(dirs);
            end
            dir_out = fourway[p] ? sel : dirs;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dirs_prev <= '0;
                held      <= '0;
                port_lo   <= '1;
            end else begin
                dirs_prev <= dirs;
                held      <= fourway[p] ? sel : '0;
                port_lo   <= ~{joystick[p][JOY_START], joystick[p][JOY_BTN1], dir_out};
            end
        end

        coin_pulser #(
            .COIN_PULSE (COIN_PULSE),
            .COIN_GAP   (COIN_GAP),
            .PEND_MAX   (PEND_MAX)
        ) u_coin (
            .clk     (clk),
            .reset_n (reset_n),
            .coin_in (joystick[p][JOY_COIN]),
            .coin_n  (coin_n),
            .busy    (coin_busy[p])
        );

        assign in_port[p] = {1'b1, coin_n, port_lo};
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
module tb_arcade_input_mapper;

  localparam int NP = 2;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NP-1:0][15:0] joystick;
  logic [NP-1:0]       fourway;
  logic [NP-1:0][7:0]  in_port;
  logic [NP-1:0]       coin_busy;

  arcade_input_mapper #(
    .PLAYERS    (NP),
    .COIN_PULSE (16'd4),
    .COIN_GAP   (16'd3),
    .PEND_MAX   (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .joystick  (joystick),
    .fourway   (fourway),
    .in_port   (in_port),
    .coin_busy (coin_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    int         p;
    int         kind;
    logic [7:0] mask;
    logic [7:0] val;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input int at, input int p, input int kind,
                      input logic [7:0] mask, input logic [7:0] val, input string nm);
    exp_t e;
    e.at = at; e.p = p; e.kind = kind; e.mask = mask; e.val = val; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at <= cyc) begin
        logic [7:0] act, want;
        act  = (exp_q[i].kind == 0) ? (in_port[exp_q[i].p] & exp_q[i].mask)
                                    : {7'b0, coin_busy[exp_q[i].p]};
        want = (exp_q[i].kind == 0) ? (exp_q[i].val & exp_q[i].mask) : exp_q[i].val;
        checks++;
        if (exp_q[i].at < cyc || act !== want) begin
          errors++;
          $display("FAIL %s cyc=%0d p%0d got=%h expected=%h (due %0d)",
                   exp_q[i].nm, cyc, exp_q[i].p, act, want, exp_q[i].at);
        end
        exp_q.delete(i);
      end
    end
  end

  int k, m, a, b, c, d, e, f, g, h, s, t, r;

  initial begin
    reset_n  = 1'b0;
    joystick = '0;
    fourway  = 2'b10;
    joystick[0] = 16'h007F;
    tick(3);

    checks++;
    if (in_port[0] !== 8'hFF || in_port[1] !== 8'hFF) begin
      errors++;
      $display("FAIL direct_rst_port got=%h/%h", in_port[0], in_port[1]);
    end
    checks++;
    if (coin_busy !== 2'b00) begin
      errors++;
      $display("FAIL direct_rst_busy got=%b", coin_busy);
    end

    push(cyc, 0, 0, 8'hFF, 8'hFF, "rst_p0");
    push(cyc, 1, 0, 8'hFF, 8'hFF, "rst_p1");
    push(cyc, 0, 1, 8'h01, 8'h00, "rst_busy0");
    tick(1);

    k = cyc;
    reset_n = 1'b1;
    push(k + 1, 0, 0, 8'hFF, 8'hC0, "rel_p0");
    push(k + 2, 0, 0, 8'hFF, 8'h80, "rel_coin");
    push(k + 1, 0, 1, 8'h01, 8'h01, "busy_on");
    for (int i = 2; i <= 5; i++) push(k + i, 0, 0, 8'h40, 8'h00, "held_pulse");
    for (int i = 6; i <= 8; i++) push(k + i, 0, 0, 8'h40, 8'h40, "held_gap");
    push(k + 8, 0, 1, 8'h01, 8'h01, "busy_gap");
    push(k + 9, 0, 1, 8'h01, 8'h00, "busy_off");
    push(k + 20,  0, 0, 8'h40, 8'h40, "held_once");
    push(k + 60,  0, 0, 8'h40, 8'h40, "held_once");
    push(k + 100, 0, 0, 8'h40, 8'h40, "held_once");
    push(k + 100, 0, 1, 8'h01, 8'h00, "held_busy");
    tick(1);
    checks++;
    if (in_port[0] !== 8'hC0) begin
      errors++;
      $display("FAIL direct_rel_p0 got=%h", in_port[0]);
    end
    tick(1);
    checks++;
    if (in_port[0] !== 8'h80) begin
      errors++;
      $display("FAIL direct_rel_coin got=%h", in_port[0]);
    end
    tick(99);

    m = cyc;
    joystick[0] = '0;
    push(m + 1, 0, 0, 8'hFF, 8'hFF, "p0_release");
    push(m + 1, 1, 0, 8'hFF, 8'hFF, "p1_idle");
    tick(3);

    a = cyc;
    joystick[1] = 16'h0008;
    push(a + 1, 1, 0, 8'hFF, 8'hFE, "4w_up");
    tick(1);
    checks++;
    if (in_port[1] !== 8'hFE) begin
      errors++;
      $display("FAIL direct_4w_up got=%h", in_port[1]);
    end
    tick(2);
    b = cyc;
    joystick[1] = 16'h0009;
    push(b + 1, 1, 0, 8'hFF, 8'hF7, "4w_new_right");
    push(b + 3, 1, 0, 8'hFF, 8'hF7, "4w_right_hold");
    tick(1);
    checks++;
    if (in_port[1] !== 8'hF7) begin
      errors++;
      $display("FAIL direct_4w_right got=%h", in_port[1]);
    end
    tick(2);
    c = cyc;
    joystick[1] = 16'h0008;
    push(c + 1, 1, 0, 8'hFF, 8'hFE, "4w_back_up");
    tick(2);
    d = cyc;
    joystick[1] = '0;
    push(d + 1, 1, 0, 8'hFF, 8'hFF, "4w_none");
    tick(2);

    e = cyc;
    joystick[1] = 16'h000A;
    push(e + 1, 1, 0, 8'hFF, 8'hFE, "4w_tie_up");
    tick(2);
    f = cyc;
    fourway[1] = 1'b0;
    push(f + 1, 1, 0, 8'hFF, 8'hFA, "8w_diag");
    tick(2);
    g = cyc;
    fourway[1] = 1'b1;
    push(g + 1, 1, 0, 8'hFF, 8'hFE, "4w_reenter");
    tick(2);
    h = cyc;
    joystick[1] = 16'h0060;
    push(h + 1, 1, 0, 8'hFF, 8'hCF, "btn_start");
    tick(2);
    joystick[1] = '0;
    tick(2);

    s = cyc;
    joystick[1] = 16'h0010;
    push(s + 1, 1, 1, 8'h01, 8'h01, "tap_busy_on");
    for (int i = 2; i <= 5; i++) push(s + i, 1, 0, 8'hC0, 8'h80, "tap_pulse");
    for (int i = 6; i <= 8; i++) push(s + i, 1, 0, 8'hC0, 8'hC0, "tap_gap");
    push(s + 8, 1, 1, 8'h01, 8'h01, "tap_busy_gap");
    push(s + 9, 1, 1, 8'h01, 8'h00, "tap_busy_off");
    push(s + 12, 1, 0, 8'hC0, 8'hC0, "tap_after");
    tick(1);
    joystick[1] = '0;
    tick(14);

    t = cyc;
    for (int i = 2; i <= 36; i++)
      push(t + i, 0, 0, 8'h40, (((i - 2) % 7) < 4) ? 8'h00 : 8'h40, "queue_pulse");
    for (int i = 37; i <= 45; i++) push(t + i, 0, 0, 8'h40, 8'h40, "queue_done");
    push(t + 36, 0, 1, 8'h01, 8'h01, "queue_busy");
    push(t + 37, 0, 1, 8'h01, 8'h00, "queue_busy_off");
    for (int j = 0; j < 6; j++) begin
      joystick[0] = 16'h0010;
      tick(1);
      joystick[0] = '0;
      tick(1);
    end
    tick(38);

    r = cyc;
    push(r + 4, 0, 0, 8'h40, 8'h00, "pre_rst_pulse");
    for (int j = 0; j < 3; j++) begin
      joystick[0] = 16'h0010;
      tick(1);
      if (j < 2) begin
        joystick[0] = '0;
        tick(1);
      end
    end
    joystick[0] = '0;
    reset_n = 1'b0;
    push(r + 5, 0, 0, 8'hFF, 8'hFF, "rst_mid_port");
    push(r + 5, 0, 1, 8'h01, 8'h00, "rst_mid_busy");
    tick(2);
    reset_n = 1'b1;
    for (int i = 8; i <= 30; i++) push(r + i, 0, 0, 8'hFF, 8'hFF, "rst_no_pulse");
    push(r + 8,  0, 1, 8'h01, 8'h00, "rst_busy_low");
    push(r + 30, 0, 1, 8'h01, 8'h00, "rst_busy_low");
    tick(30);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick(1);
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s never checked (due %0d)", exp_q[0].nm, exp_q[0].at);
      void'(exp_q.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
